hack_cpu_ctrl: RTL and testbench
================================

Name: hack_cpu_ctrl

Overview:
Multi-cycle Hack CPU control and register stage that sits directly upstream of the 16-bit ALU. It fetches instructions over a valid/ready handshake, holds the A, D and PC registers, and reads the M operand from data memory when an instruction needs it. It drives the ALU operands and the six control bits (zx nx zy ny f no), then consumes the ALU result and the zr/ng flags for write-back and jump resolution.

Parameters:
WIDTH, 16, datapath and register width (Hack ISA fixed at 16)
PC_RESET, 16'h0000, PC value after reset

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr  in  WIDTH  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  controller accepts instr this cycle
pc  out  WIDTH  address of the next instruction to fetch
mem_addr  out  WIDTH  data memory address (always the current A)
mem_rd_req  out  1  M read request
mem_rd_valid  in  1  mem_rd_data is valid
mem_rd_data  in  WIDTH  M read data
mem_wr_en  out  1  M write strobe (writeM)
mem_wr_data  out  WIDTH  M write data (outM)
mem_wr_ack  in  1  write accepted
alu_x, alu_y  out  WIDTH  ALU operands
alu_ctrl  out  6  {zx,nx,zy,ny,f,no}
alu_out  in  WIDTH  ALU result
alu_zr, alu_ng  in  1  ALU flags
halted  out  1  see Optional Feature (tied 0 when the feature is compiled out)

Behaviour:
- Reset (asynchronous, reset_n=0): A=0, D=0, PC=PC_RESET, state=FETCH. All request and strobe outputs are 0. alu_ctrl, mem_wr_data and mem_addr are 0. Reset mid-transaction drops the transaction immediately; no completion is expected.
- Decode: instr[15]=0 is an A-instruction (A <= {1'b0, instr[14:0]}). instr[15]=1 is a C-instruction: a=instr[12], c=instr[11:6], d=instr[5:3] (dA, dD, dM), j=instr[2:0] (lt, eq, gt). instr[14:13] are ignored.
- FSM states: FETCH, READ_M, EXEC, WRITE_M.
- FETCH:
  - instr_ready=1. When instr_valid=1, latch instr.
  - A-instruction: update A, set PC <= PC+1, stay in FETCH. This gives 1 cycle per A-instruction.
  - C-instruction with a=1: go to READ_M. Otherwise go to EXEC.
- READ_M:
  - mem_rd_req=1 and held until mem_rd_valid=1. Latch mem_rd_data into an M register, then go to EXEC.
  - mem_rd_valid in the same cycle the request rises is legal. The minimum stay is 1 cycle.
- EXEC:
  - Combinational drive: alu_x=D, alu_y=(a ? M : A), alu_ctrl=c.
  - On the clock edge:
    - jump = (lt&ng) | (eq&zr) | (gt&~ng&~zr).
    - PC <= jump ? A_old : PC+1.
    - D <= alu_out if dD.
    - A <= alu_out if dA.
  - If dM: latch alu_out into mem_wr_data and go to WRITE_M. Otherwise go to FETCH.
- WRITE_M: mem_wr_en=1 and held until mem_wr_ack=1, then go to FETCH. mem_addr stays at A_old for the whole write. The A update is deferred to the end of WRITE_M.
- Old-value rule: jump target, M read address and M write address all use the A value from before the current instruction writes A. This matches Hack single-cycle semantics.
- PC wraps modulo 2^WIDTH: 16'hFFFF + 1 = 16'h0000.
- Outside EXEC, alu_ctrl is 0 and alu_x/alu_y are held at D/A. The ALU result is ignored in those states.
- instr_ready is 0 in every state other than FETCH (and while halted).

Optional Feature:
- Macro: HACK_CPU_HALT_EN.
- When defined: in EXEC, an unconditional jump (j=3'b111) whose target A_old equals the PC of the current instruction sets halted=1. After that, instr_ready stays 0 and the FSM parks in FETCH until reset. Registers hold their values.
- When undefined: halted is tied 0 and the jump executes normally, so the controller loops forever.

Test Plan:
- Reset with reset_n=0 mid-READ_M -> pc=PC_RESET, A=D=0, mem_rd_req=0 immediately, asynchronously.
- A-instr 16'h0005, then C-instr D=A (16'hEC10) -> alu_ctrl=6'b110000, D=5, PC advances 0->1->2, no memory traffic.
- @100, then M=D+1 (16'hE7C8, with D=7) -> mem_wr_en=1 with mem_addr=100 and mem_wr_data=8, held 3 cycles until mem_wr_ack; PC=2 afterwards.
- D=M (16'hFC10) with mem_rd_valid delayed 4 cycles, read data 16'h8000 -> mem_rd_req held, D=16'h8000. Then D;JLT (16'hE304) with A=40 -> ng=1, PC=40.
- AM=M-1 (16'hFCA8) with A=50, M=1 -> write of 0 to address 50, A=0 after the write. D;JEQ (16'hE302) then jumps to 0.
- HACK_CPU_HALT_EN: PC=10, @10, 0;JMP -> halted=1, instr_ready=0 indefinitely. Without the macro -> PC returns to 10 on every iteration.

Source files
------------

// File: rtl/hack_cpu_ctrl_if.sv
// Hack CPU controller bus: instruction fetch, data memory and ALU signals in one bundle.
// master = controller side, slave = fetch/memory/ALU side.
interface hack_cpu_ctrl_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] instr;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] mem_addr;
   logic             mem_rd_req;
   logic             mem_rd_valid;
   logic [WIDTH-1:0] mem_rd_data;
   logic             mem_wr_en;
   logic [WIDTH-1:0] mem_wr_data;
   logic             mem_wr_ack;
   logic [WIDTH-1:0] alu_x;
   logic [WIDTH-1:0] alu_y;
   logic [5:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zr;
   logic             alu_ng;
   logic             halted;

   modport master (
      input  instr, instr_valid, mem_rd_valid, mem_rd_data, mem_wr_ack,
             alu_out, alu_zr, alu_ng,
      output instr_ready, pc, mem_addr, mem_rd_req, mem_wr_en, mem_wr_data,
             alu_x, alu_y, alu_ctrl, halted
   );

   modport slave (
      output instr, instr_valid, mem_rd_valid, mem_rd_data, mem_wr_ack,
             alu_out, alu_zr, alu_ng,
      input  instr_ready, pc, mem_addr, mem_rd_req, mem_wr_en, mem_wr_data,
             alu_x, alu_y, alu_ctrl, halted
   );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control/register stage: A-instr 1 cycle, C-instr 2 cycles plus M read/write waits.
// Fetch stalls via instr_ready outside FETCH; optional self-loop halt under HACK_CPU_HALT_EN.
module hack_cpu_ctrl #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = 16'h0000
) (
   input logic             i_clock,
   input logic             i_reset_n,
   hack_cpu_ctrl_if.master io_bus
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      READ_M  = 2'd1,
      EXEC    = 2'd2,
      WRITE_M = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_m;
   logic             r_sel_m;
   logic [5:0]       r_c;
   logic [2:0]       r_dst;
   logic [2:0]       r_jmp;
   logic [5:0]       r_alu_ctrl;
   logic             r_rd_req;
   logic             r_wr_en;
   logic [WIDTH-1:0] r_wr_data;
   logic             r_a_pend;

   logic [WIDTH-1:0] w_pc_inc;
   logic             w_jump;
   logic             w_instr_ready;
   logic             w_unused;

   assign w_pc_inc = r_pc + WIDTH'(1);
   assign w_jump   = (r_jmp[2] & io_bus.alu_ng)
                   | (r_jmp[1] & io_bus.alu_zr)
                   | (r_jmp[0] & ~io_bus.alu_ng & ~io_bus.alu_zr);
   assign w_unused = ^io_bus.instr[14:13];

`ifdef HACK_CPU_HALT_EN
   logic r_halted;
   logic w_halt;

   // A self-targeting unconditional jump can never make progress, so park.
   assign w_halt        = (r_jmp == 3'b111) && (r_a == r_pc);
   assign w_instr_ready = (r_state == FETCH) && !r_halted;
   assign io_bus.halted = r_halted;
`else
   assign w_instr_ready = (r_state == FETCH);
   assign io_bus.halted = 1'b0;
`endif

   assign io_bus.instr_ready = w_instr_ready;
   assign io_bus.pc          = r_pc;
   assign io_bus.mem_addr    = r_a;
   assign io_bus.mem_rd_req  = r_rd_req;
   assign io_bus.mem_wr_en   = r_wr_en;
   assign io_bus.mem_wr_data = r_wr_data;
   assign io_bus.alu_ctrl    = r_alu_ctrl;
   assign io_bus.alu_x       = r_d;
   assign io_bus.alu_y       = ((r_state == EXEC) && r_sel_m) ? r_m : r_a;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= FETCH;
         r_a        <= '0;
         r_d        <= '0;
         r_pc       <= PC_RESET;
         r_m        <= '0;
         r_sel_m    <= 1'b0;
         r_c        <= '0;
         r_dst      <= '0;
         r_jmp      <= '0;
         r_alu_ctrl <= '0;
         r_rd_req   <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= '0;
         r_a_pend   <= 1'b0;
`ifdef HACK_CPU_HALT_EN
         r_halted   <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH: begin
               if (w_instr_ready && io_bus.instr_valid) begin
                  if (!io_bus.instr[WIDTH-1]) begin
                     r_a  <= {1'b0, io_bus.instr[WIDTH-2:0]};
                     r_pc <= w_pc_inc;
                  end else begin
                     r_sel_m <= io_bus.instr[12];
                     r_c     <= io_bus.instr[11:6];
                     r_dst   <= io_bus.instr[5:3];
                     r_jmp   <= io_bus.instr[2:0];
                     if (io_bus.instr[12]) begin
                        r_rd_req <= 1'b1;
                        r_state  <= READ_M;
                     end else begin
                        r_alu_ctrl <= io_bus.instr[11:6];
                        r_state    <= EXEC;
                     end
                  end
               end
            end
            READ_M: begin
               if (io_bus.mem_rd_valid) begin
                  r_m        <= io_bus.mem_rd_data;
                  r_rd_req   <= 1'b0;
                  r_alu_ctrl <= r_c;
                  r_state    <= EXEC;
               end
            end
            EXEC: begin
               r_alu_ctrl <= '0;
               r_pc       <= w_jump ? r_a : w_pc_inc;
               if (r_dst[1]) r_d <= io_bus.alu_out;
               // With a pending M write, A must keep addressing the old location until the ack.
               if (r_dst[0]) begin
                  r_wr_data <= io_bus.alu_out;
                  r_wr_en   <= 1'b1;
                  r_a_pend  <= r_dst[2];
                  r_state   <= WRITE_M;
               end else begin
                  if (r_dst[2]) r_a <= io_bus.alu_out;
                  r_state <= FETCH;
               end
`ifdef HACK_CPU_HALT_EN
               if (w_halt) r_halted <= 1'b1;
`endif
            end
            WRITE_M: begin
               if (io_bus.mem_wr_ack) begin
                  r_wr_en  <= 1'b0;
                  r_a_pend <= 1'b0;
                  if (r_a_pend) r_a <= r_wr_data;
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: acts as fetch source, data memory and ALU, checking against an ISA-level model.
// Halt expectations follow HACK_CPU_HALT_EN.
module tb_hack_cpu_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   hack_cpu_ctrl_if #(.WIDTH(16)) bus ();

   hack_cpu_ctrl #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .io_bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
      logic [15:0] xx, yy, r;
      xx = c[5] ? 16'h0000 : x;
      xx = c[4] ? ~xx : xx;
      yy = c[3] ? 16'h0000 : y;
      yy = c[2] ? ~yy : yy;
      r  = c[1] ? (xx + yy) : (xx & yy);
      return c[0] ? ~r : r;
   endfunction

   assign bus.alu_out = hack_alu(bus.alu_x, bus.alu_y, bus.alu_ctrl);
   assign bus.alu_zr  = (bus.alu_out == 16'h0000);
   assign bus.alu_ng  = bus.alu_out[15];

   // ISA-level machine state
   logic [15:0] mem [0:65535];
   logic [15:0] m_a, m_d, m_pc;
   bit          m_halted;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_instr(input logic [15:0] ins, input int rd_lat, input int wr_lat);
      logic [15:0] a_old, pc_cur, y, res;
      bit          jmp;
      if (m_halted) begin
         for (int k = 0; k < 3; k++) begin
            chk("halt_ready", {15'd0, bus.instr_ready}, 16'd0);
            chk("halt_flag", {15'd0, bus.halted}, 16'd1);
            chk("halt_pc", bus.pc, m_pc);
            bus.instr = ins;
            bus.instr_valid = 1'b1;
            @(negedge clk);
         end
         bus.instr_valid = 1'b0;
         return;
      end
      chk("fetch_ready", {15'd0, bus.instr_ready}, 16'd1);
      chk("fetch_pc", bus.pc, m_pc);
      chk("fetch_a", bus.mem_addr, m_a);
      chk("fetch_d", bus.alu_x, m_d);
      chk("fetch_ctrl", {10'd0, bus.alu_ctrl}, 16'd0);
      chk("fetch_halted", {15'd0, bus.halted}, 16'd0);
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr = 16'($urandom);
      if (!ins[15]) begin
         m_a  = {1'b0, ins[14:0]};
         m_pc = m_pc + 16'd1;
         return;
      end
      a_old  = m_a;
      pc_cur = m_pc;
      y      = m_a;
      if (ins[12]) begin
         for (int k = 0; k < rd_lat; k++) begin
            chk("rd_req_wait", {15'd0, bus.mem_rd_req}, 16'd1);
            chk("rd_addr", bus.mem_addr, a_old);
            chk("rd_ctrl", {10'd0, bus.alu_ctrl}, 16'd0);
            @(negedge clk);
         end
         chk("rd_req", {15'd0, bus.mem_rd_req}, 16'd1);
         chk("rd_ready", {15'd0, bus.instr_ready}, 16'd0);
         bus.mem_rd_valid = 1'b1;
         bus.mem_rd_data  = mem[a_old];
         y = mem[a_old];
         @(negedge clk);
         bus.mem_rd_valid = 1'b0;
         bus.mem_rd_data  = 16'($urandom);
      end
      chk("exec_ctrl", {10'd0, bus.alu_ctrl}, {10'd0, ins[11:6]});
      chk("exec_x", bus.alu_x, m_d);
      chk("exec_y", bus.alu_y, y);
      chk("exec_rd_req", {15'd0, bus.mem_rd_req}, 16'd0);
      chk("exec_wr_en", {15'd0, bus.mem_wr_en}, 16'd0);
      chk("exec_ready", {15'd0, bus.instr_ready}, 16'd0);
      res = hack_alu(m_d, y, ins[11:6]);
      jmp = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0000)
         || (ins[0] && $signed(res) > 0);
      @(negedge clk);
      m_pc = jmp ? a_old : (m_pc + 16'd1);
      if (ins[4]) m_d = res;
      if (ins[3]) begin
         for (int k = 0; k <= wr_lat; k++) begin
            chk("wr_en", {15'd0, bus.mem_wr_en}, 16'd1);
            chk("wr_data", bus.mem_wr_data, res);
            chk("wr_addr", bus.mem_addr, a_old);
            chk("wr_ready", {15'd0, bus.instr_ready}, 16'd0);
            if (k == wr_lat) bus.mem_wr_ack = 1'b1;
            @(negedge clk);
         end
         bus.mem_wr_ack = 1'b0;
         mem[a_old] = res;
         chk("wr_done", {15'd0, bus.mem_wr_en}, 16'd0);
      end
      if (ins[5]) m_a = res;
`ifdef HACK_CPU_HALT_EN
      if (ins[2:0] == 3'b111 && a_old == pc_cur) m_halted = 1'b1;
`else
      if (pc_cur == 16'hFFFF) m_halted = 1'b0;
`endif
   endtask

   task automatic model_reset();
      m_a = 16'h0000;
      m_d = 16'h0000;
      m_pc = 16'h0000;
      m_halted = 1'b0;
   endtask

   initial begin
      logic [15:0] ri;
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      bus.instr = 16'h0000;
      bus.instr_valid = 1'b0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data = 16'h0000;
      bus.mem_wr_ack = 1'b0;
      model_reset();

      repeat (2) @(negedge clk);
      chk("rst_pc", bus.pc, 16'h0000);
      chk("rst_addr", bus.mem_addr, 16'h0000);
      chk("rst_d", bus.alu_x, 16'h0000);
      chk("rst_rd_req", {15'd0, bus.mem_rd_req}, 16'd0);
      chk("rst_wr_en", {15'd0, bus.mem_wr_en}, 16'd0);
      chk("rst_wr_data", bus.mem_wr_data, 16'h0000);
      chk("rst_ctrl", {10'd0, bus.alu_ctrl}, 16'd0);
      chk("rst_halted", {15'd0, bus.halted}, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // @5; D=A
      do_instr(16'h0005, 0, 0);
      do_instr(16'hEC10, 0, 0);
      chk("d_eq_5", bus.alu_x, 16'd5);
      chk("pc_2", bus.pc, 16'd2);
      // @7; D=A; @100; M=D+1 with a slow ack
      do_instr(16'h0007, 0, 0);
      do_instr(16'hEC10, 0, 0);
      do_instr(16'h0064, 0, 0);
      do_instr(16'hE7C8, 0, 3);
      chk("mem100", mem[100], 16'd8);
      // @30; D=M with late read data; @40; D;JLT
      mem[30] = 16'h8000;
      do_instr(16'h001E, 0, 0);
      do_instr(16'hFC10, 4, 0);
      chk("d_8000", bus.alu_x, 16'h8000);
      do_instr(16'h0028, 0, 0);
      do_instr(16'hE304, 0, 0);
      chk("jlt_pc", bus.pc, 16'd40);
      // @50; AM=M-1 (A update deferred past the write); D=0; D;JEQ
      mem[50] = 16'h0001;
      do_instr(16'h0032, 0, 0);
      do_instr(16'hFCA8, 1, 2);
      chk("am_a", bus.mem_addr, 16'h0000);
      chk("mem50", mem[50], 16'h0000);
      do_instr(16'hEA90, 0, 0);
      do_instr(16'hE302, 0, 0);
      chk("jeq_pc", bus.pc, 16'h0000);

      // Reset in the middle of READ_M
      do_instr(16'h004D, 0, 0);
      do_instr(16'hEC10, 0, 0);
      bus.instr = 16'hFC10;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      chk("mid_rd_req", {15'd0, bus.mem_rd_req}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rd_req", {15'd0, bus.mem_rd_req}, 16'd0);
      chk("arst_pc", bus.pc, 16'h0000);
      chk("arst_a", bus.mem_addr, 16'h0000);
      chk("arst_d", bus.alu_x, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);

      // Random programs
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            ri = 16'($urandom_range(0, 255));
         end else begin
            ri = {3'b111, 13'($urandom)};
            if (ri[2:0] == 3'b111 && m_a == m_pc) ri[2:0] = 3'b000;
         end
         do_instr(ri, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Self-loop: @10; 0;JMP reaches PC=10 with A=10, then 0;JMP at PC 10
      do_instr(16'h000A, 0, 0);
      do_instr(16'hEA87, 0, 0);
      for (int n = 0; n < 3; n++) begin
         do_instr(16'hEA87, 0, 0);
         chk("loop_pc", bus.pc, 16'd10);
      end
`ifdef HACK_CPU_HALT_EN
      chk("halted_end", {15'd0, bus.halted}, 16'd1);
      chk("halted_ready", {15'd0, bus.instr_ready}, 16'd0);
`else
      chk("no_halt", {15'd0, bus.halted}, 16'd0);
      chk("loop_ready", {15'd0, bus.instr_ready}, 16'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
